// File: rtl/acl2_pkg.sv
// Shared ADXL362 (ACL2) definitions: SPI command bytes, register map, arbiter states.
package acl2_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h0A;
  localparam logic [7:0] CMD_READ  = 8'h0B;

  localparam logic [7:0] REG_DEVID_AD   = 8'h00;
  localparam logic [7:0] REG_XDATA_L    = 8'h0E;
  localparam logic [7:0] REG_FILTER_CTL = 8'h2C;
  localparam logic [7:0] REG_POWER_CTL  = 8'h2D;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SEND,
    ST_WAIT,
    ST_HOLD,
    ST_GAP
  } state_t;

  // Byte idx of a frame: command, address, then write data or read dummy.
  function automatic logic [7:0] frame_byte(input logic write, input logic [7:0] addr,
                                            input logic [7:0] wdata, input int unsigned idx);
    if (idx == 0) return write ? CMD_WRITE : CMD_READ;
    if (idx == 1) return addr;
    return write ? wdata : 8'h00;
  endfunction

endpackage

// File: rtl/spi_arbiter_if.sv
// Requester, read-return and SPI-engine signals of the ACL2 SPI arbiter.
interface spi_arbiter_if;

  logic       req0_valid;
  logic       req0_write;
  logic [7:0] req0_addr;
  logic [7:0] req0_wdata;
  logic [3:0] req0_len;
  logic       req0_ready;

  logic       req1_valid;
  logic       req1_write;
  logic [7:0] req1_addr;
  logic [7:0] req1_wdata;
  logic [3:0] req1_len;
  logic       req1_ready;

  logic       rd_valid;
  logic [7:0] rd_data;
  logic       rd_id;
  logic       done;
  logic       error;

  logic       start;
  logic [7:0] tx_data;
  logic       active;
  logic [7:0] rx_data;
  logic       ncs_o;
  logic       clk_enable;

  // Arbiter side.
  modport master (
    input  req0_valid, req0_write, req0_addr, req0_wdata, req0_len,
    input  req1_valid, req1_write, req1_addr, req1_wdata, req1_len,
    output req0_ready, req1_ready,
    output rd_valid, rd_data, rd_id, done, error,
    output start, tx_data, ncs_o, clk_enable,
    input  active, rx_data
  );

  // Requesters plus SPI engine side.
  modport slave (
    output req0_valid, req0_write, req0_addr, req0_wdata, req0_len,
    output req1_valid, req1_write, req1_addr, req1_wdata, req1_len,
    input  req0_ready, req1_ready,
    input  rd_valid, rd_data, rd_id, done, error,
    input  start, tx_data, ncs_o, clk_enable,
    output active, rx_data
  );

endinterface

// File: rtl/spi_arbiter.sv
// Two-requester round-robin owner of the byte-level SPI engine and ACL2 chip select.
module spi_arbiter
  import acl2_pkg::*;
#(
  parameter int unsigned MAX_BURST   = 8,
  parameter int unsigned CS_SETUP    = 4,
  parameter int unsigned CS_GAP      = 16,
  parameter int unsigned ACT_TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          rst,
  spi_arbiter_if.master bus
);

  localparam int unsigned IDX_W = $clog2(MAX_BURST + 2);
  localparam int unsigned TMR_W = $clog2(ACT_TIMEOUT + 1);

  state_t           state_q, state_d;
  logic             rr_q, rr_d;
  logic             owner_q, owner_d;
  logic             write_q, write_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [TMR_W-1:0] tmr_q, tmr_d, tmr_inc;
  logic             seen_q, seen_d;
  logic             err_q, err_d;

  logic             ready0_q, ready0_d, ready1_q, ready1_d;
  logic             rd_valid_q, rd_valid_d;
  logic [7:0]       rd_data_q, rd_data_d;
  logic             rd_id_q, rd_id_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic             start_q, start_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             ncs_q, ncs_d;
  logic             clk_en_q, clk_en_d;

  logic             sel;
  logic [3:0]       len_sel;
  int unsigned      len_n;

  // Saturating phase timer increment.
  assign tmr_inc = (&tmr_q) ? tmr_q : tmr_q + TMR_W'(1);

  // Next-state, arbitration, framing and output decode.
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    owner_d    = owner_q;
    write_d    = write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    idx_d      = idx_q;
    last_d     = last_q;
    tmr_d      = tmr_q;
    seen_d     = seen_q;
    err_d      = err_q;
    ready0_d   = 1'b0;
    ready1_d   = 1'b0;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    rd_id_d    = rd_id_q;
    done_d     = 1'b0;
    error_d    = 1'b0;
    start_d    = 1'b0;
    tx_data_d  = tx_data_q;
    ncs_d      = ncs_q;
    clk_en_d   = clk_en_q;
    sel        = 1'b0;
    len_sel    = 4'd0;
    len_n      = 0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.req0_valid || bus.req1_valid) begin
          // On a tie the pointer names the requester not served last.
          sel      = (bus.req0_valid && bus.req1_valid) ? rr_q : bus.req1_valid;
          rr_d     = ~sel;
          owner_d  = sel;
          write_d  = sel ? bus.req1_write : bus.req0_write;
          addr_d   = sel ? bus.req1_addr  : bus.req0_addr;
          wdata_d  = sel ? bus.req1_wdata : bus.req0_wdata;
          len_sel  = sel ? bus.req1_len   : bus.req0_len;
          len_n    = 32'(len_sel);
          if (len_n == 0) len_n = 1;
          else if (len_n > MAX_BURST) len_n = MAX_BURST;
          last_d   = write_d ? IDX_W'(2) : IDX_W'(len_n + 1);
          ready0_d = ~sel;
          ready1_d = sel;
          idx_d    = '0;
          tmr_d    = '0;
          seen_d   = 1'b0;
          err_d    = 1'b0;
          ncs_d    = 1'b0;
          clk_en_d = 1'b1;
          state_d  = ST_SETUP;
        end
      end

      ST_SETUP: begin
        tmr_d = tmr_inc;
        if (tmr_q >= TMR_W'(CS_SETUP - 1)) begin
          start_d   = 1'b1;
          tx_data_d = frame_byte(write_q, addr_q, wdata_q, 0);
          tmr_d     = '0;
          state_d   = ST_SEND;
        end
      end

      ST_SEND: begin
        tmr_d   = tmr_inc;
        seen_d  = 1'b0;
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        tmr_d = tmr_inc;
        if (!seen_q) begin
          if (bus.active) begin
            seen_d = 1'b1;
          end else if (tmr_q >= TMR_W'(ACT_TIMEOUT)) begin
            err_d   = 1'b1;
            ncs_d   = 1'b1;
            state_d = ST_HOLD;
          end
        end else if (!bus.active) begin
          if (!write_q && idx_q >= IDX_W'(2)) begin
            rd_valid_d = 1'b1;
            rd_data_d  = bus.rx_data;
            rd_id_d    = owner_q;
          end
          if (idx_q == last_q) begin
            ncs_d   = 1'b1;
            state_d = ST_HOLD;
          end else begin
            idx_d     = idx_q + IDX_W'(1);
            start_d   = 1'b1;
            tx_data_d = frame_byte(write_q, addr_q, wdata_q, 32'(idx_q) + 32'd1);
            tmr_d     = '0;
            state_d   = ST_SEND;
          end
        end
      end

      ST_HOLD: begin
        done_d   = 1'b1;
        error_d  = err_q;
        rd_id_d  = owner_q;
        clk_en_d = 1'b0;
        tmr_d    = '0;
        state_d  = ST_GAP;
      end

      ST_GAP: begin
        tmr_d = tmr_inc;
        if (tmr_q >= TMR_W'(CS_GAP - 1)) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; reset deasserts chip select at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rr_q       <= 1'b0;
      owner_q    <= 1'b0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      idx_q      <= '0;
      last_q     <= '0;
      tmr_q      <= '0;
      seen_q     <= 1'b0;
      err_q      <= 1'b0;
      ready0_q   <= 1'b0;
      ready1_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_id_q    <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      start_q    <= 1'b0;
      tx_data_q  <= '0;
      ncs_q      <= 1'b1;
      clk_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      owner_q    <= owner_d;
      write_q    <= write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
      tmr_q      <= tmr_d;
      seen_q     <= seen_d;
      err_q      <= err_d;
      ready0_q   <= ready0_d;
      ready1_q   <= ready1_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_id_q    <= rd_id_d;
      done_q     <= done_d;
      error_q    <= error_d;
      start_q    <= start_d;
      tx_data_q  <= tx_data_d;
      ncs_q      <= ncs_d;
      clk_en_q   <= clk_en_d;
    end
  end

  assign bus.req0_ready = ready0_q;
  assign bus.req1_ready = ready1_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.rd_data    = rd_data_q;
  assign bus.rd_id      = rd_id_q;
  assign bus.done       = done_q;
  assign bus.error      = error_q;
  assign bus.start      = start_q;
  assign bus.tx_data    = tx_data_q;
  assign bus.ncs_o      = ncs_q;
  assign bus.clk_enable = clk_en_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter with a simple byte-engine responder.
module tb_spi_arbiter;
  import acl2_pkg::*;

  localparam int unsigned MAX_BURST   = 8;
  localparam int unsigned CS_SETUP    = 4;
  localparam int unsigned CS_GAP      = 16;
  localparam int unsigned ACT_TIMEOUT = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_arbiter_if bus ();

  spi_arbiter #(
    .MAX_BURST  (MAX_BURST),
    .CS_SETUP   (CS_SETUP),
    .CS_GAP     (CS_GAP),
    .ACT_TIMEOUT(ACT_TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] tx_log[$];
  logic [8:0] rd_log[$];
  int         gnt_log[$];
  logic [2:0] done_log[$];
  int         gap_log[$];
  logic [7:0] rx_q[$];

  int cyc = 0, start_cyc = 0, done_cyc = 0;
  int hi_run = 0, lo_run = 0, setup_lo = 0;
  int pend0 = 0, pend1 = 0;
  int eng_cnt = 0;
  bit eng_dead = 0;

  // Observe DUT outputs mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (bus.start) begin
        if (tx_log.size() == 0) setup_lo = lo_run;
        tx_log.push_back(bus.tx_data);
        start_cyc = cyc;
      end
      if (bus.rd_valid) rd_log.push_back({bus.rd_id, bus.rd_data});
      if (bus.req0_ready && bus.req1_ready) gnt_log.push_back(2);
      else if (bus.req0_ready) gnt_log.push_back(0);
      else if (bus.req1_ready) gnt_log.push_back(1);
      if (bus.done) begin
        done_log.push_back({bus.ncs_o, bus.error, bus.rd_id});
        done_cyc = cyc;
      end
      if (bus.ncs_o) begin
        hi_run++;
        lo_run = 0;
      end else begin
        if (hi_run > 0) gap_log.push_back(hi_run);
        hi_run = 0;
        lo_run++;
      end
    end
  end

  // SPI engine: active high for two cycles after each start, returns next rx byte.
  always @(negedge clk) begin
    if (rst) begin
      bus.active = 1'b0;
      eng_cnt = 0;
    end else if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) bus.active = 1'b0;
    end else if (bus.start && !eng_dead) begin
      bus.active  = 1'b1;
      bus.rx_data = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hFF;
      eng_cnt = 2;
    end
  end

  // Requesters keep valid until all queued transactions have been accepted.
  always @(negedge clk) begin
    if (!rst && bus.req0_ready && pend0 > 0) begin
      pend0--;
      if (pend0 == 0) bus.req0_valid = 1'b0;
    end
    if (!rst && bus.req1_ready && pend1 > 0) begin
      pend1--;
      if (pend1 == 0) bus.req1_valid = 1'b0;
    end
  end

  task automatic clear_logs();
    tx_log.delete(); rd_log.delete(); gnt_log.delete();
    done_log.delete(); gap_log.delete();
  endtask

  task automatic issue(input int n, input bit w, input logic [7:0] a,
                       input logic [7:0] d, input logic [3:0] len, input int cnt);
    if (n == 0) begin
      bus.req0_write = w; bus.req0_addr = a; bus.req0_wdata = d; bus.req0_len = len;
      pend0 = cnt; bus.req0_valid = 1'b1;
    end else begin
      bus.req1_write = w; bus.req1_addr = a; bus.req1_wdata = d; bus.req1_len = len;
      pend1 = cnt; bus.req1_valid = 1'b1;
    end
  endtask

  task automatic wait_done(input int n, input int max_cyc, output bit ok);
    int c = 0;
    while (done_log.size() < n && c < max_cyc) begin
      @(negedge clk);
      c++;
    end
    ok = (done_log.size() >= n);
    repeat (CS_GAP + 8) @(negedge clk);
  endtask

  task automatic test_reset();
    n_tests++;
    if (bus.ncs_o !== 1'b1) begin
      n_fail++; $display("FAIL reset_ncs: got %b expected 1", bus.ncs_o);
    end
    n_tests++;
    if ({bus.start, bus.req0_ready, bus.req1_ready, bus.rd_valid, bus.done, bus.error,
         bus.clk_enable, bus.rd_id, bus.tx_data, bus.rd_data} !== 24'h0) begin
      n_fail++; $display("FAIL reset_outputs: got start=%b tx=%h clk_en=%b done=%b expected all 0",
                         bus.start, bus.tx_data, bus.clk_enable, bus.done);
    end
  endtask

  task automatic test_write();
    bit ok;
    logic [7:0] exp_tx[3];
    exp_tx = '{8'h0A, 8'h2D, 8'h02};
    clear_logs();
    @(negedge clk);
    issue(0, 1'b1, REG_POWER_CTL, 8'h02, 4'd0, 1);
    wait_done(1, 400, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL write_done_timeout: got no done expected 1"); end
    n_tests++;
    if (gnt_log.size() != 1 || gnt_log[0] != 0) begin
      n_fail++; $display("FAIL write_ready0: got %0d grants expected one req0 pulse", gnt_log.size());
    end
    n_tests++;
    if (setup_lo != CS_SETUP) begin
      n_fail++; $display("FAIL write_cs_setup: got %0d expected %0d", setup_lo, CS_SETUP);
    end
    n_tests++;
    if (tx_log.size() != 3) begin
      n_fail++; $display("FAIL write_starts: got %0d expected 3", tx_log.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_tests++;
        if (tx_log[i] !== exp_tx[i]) begin
          n_fail++; $display("FAIL write_tx[%0d]: got %h expected %h", i, tx_log[i], exp_tx[i]);
        end
      end
    end
    n_tests++;
    if (rd_log.size() != 0) begin
      n_fail++; $display("FAIL write_no_rd: got %0d expected 0", rd_log.size());
    end
    n_tests++;
    if (done_log.size() != 1 || done_log[0] !== 3'b100) begin
      n_fail++; $display("FAIL write_done: got %0d/%b expected 1/100 (ncs,err,id)",
                         done_log.size(), done_log.size() ? done_log[0] : 3'bx);
    end
    n_tests++;
    if (bus.ncs_o !== 1'b1 || bus.clk_enable !== 1'b0) begin
      n_fail++; $display("FAIL write_after: got ncs=%b clk_en=%b expected 1/0", bus.ncs_o, bus.clk_enable);
    end
  endtask

  task automatic test_read();
    bit ok;
    clear_logs();
    rx_q.delete();
    rx_q.push_back(8'hEE); rx_q.push_back(8'hEE);
    for (int i = 0; i < 6; i++) rx_q.push_back(8'(8'h11 + i));
    @(negedge clk);
    issue(1, 1'b0, REG_XDATA_L, 8'h55, 4'd6, 1);
    wait_done(1, 600, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL read_done_timeout: got no done expected 1"); end
    n_tests++;
    if (tx_log.size() != 8) begin
      n_fail++; $display("FAIL read_starts: got %0d expected 8", tx_log.size());
    end else begin
      n_tests++;
      if (tx_log[0] !== 8'h0B || tx_log[1] !== 8'h0E) begin
        n_fail++; $display("FAIL read_hdr: got %h %h expected 0b 0e", tx_log[0], tx_log[1]);
      end
      for (int i = 2; i < 8; i++) begin
        n_tests++;
        if (tx_log[i] !== 8'h00) begin
          n_fail++; $display("FAIL read_dummy[%0d]: got %h expected 00", i, tx_log[i]);
        end
      end
    end
    n_tests++;
    if (rd_log.size() != 6) begin
      n_fail++; $display("FAIL read_count: got %0d expected 6", rd_log.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_tests++;
        if (rd_log[i] !== {1'b1, 8'(8'h11 + i)}) begin
          n_fail++; $display("FAIL read_byte[%0d]: got %h expected %h", i, rd_log[i], {1'b1, 8'(8'h11 + i)});
        end
      end
    end
    n_tests++;
    if (done_log.size() != 1 || done_log[0] !== 3'b101) begin
      n_fail++; $display("FAIL read_done: got %0d entries expected one with ncs=1 err=0 id=1", done_log.size());
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    clear_logs();
    @(negedge clk);
    issue(0, 1'b1, REG_FILTER_CTL, 8'h13, 4'd0, 2);
    issue(1, 1'b1, REG_POWER_CTL,  8'h02, 4'd0, 2);
    wait_done(4, 2000, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL rr_done_timeout: got %0d dones expected 4", done_log.size()); end
    n_tests++;
    if (gnt_log.size() != 4) begin
      n_fail++; $display("FAIL rr_grants: got %0d expected 4", gnt_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (gnt_log[i] != (i % 2)) begin
          n_fail++; $display("FAIL rr_order[%0d]: got %0d expected %0d", i, gnt_log[i], i % 2);
        end
      end
    end
    n_tests++;
    if (gap_log.size() != 4) begin
      n_fail++; $display("FAIL rr_cs_frames: got %0d expected 4", gap_log.size());
    end else begin
      for (int i = 1; i < 4; i++) begin
        n_tests++;
        if (gap_log[i] < CS_GAP) begin
          n_fail++; $display("FAIL rr_gap[%0d]: got %0d expected >= %0d", i, gap_log[i], CS_GAP);
        end
      end
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int lat;
    clear_logs();
    eng_dead = 1;
    @(negedge clk);
    issue(0, 1'b1, REG_POWER_CTL, 8'h00, 4'd0, 1);
    wait_done(1, 1500, ok);
    lat = done_cyc - start_cyc;
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL to_done_timeout: got no done expected 1"); end
    n_tests++;
    if (done_log.size() != 1 || done_log[0] !== 3'b110) begin
      n_fail++; $display("FAIL to_done_error: got %0d entries expected one with ncs=1 err=1 id=0", done_log.size());
    end
    n_tests++;
    if (lat < ACT_TIMEOUT || lat > ACT_TIMEOUT + 4) begin
      n_fail++; $display("FAIL to_latency: got %0d expected %0d..%0d", lat, ACT_TIMEOUT, ACT_TIMEOUT + 4);
    end
    n_tests++;
    if (tx_log.size() != 1) begin
      n_fail++; $display("FAIL to_starts: got %0d expected 1", tx_log.size());
    end
    eng_dead = 0;
    clear_logs();
    rx_q.delete();
    rx_q.push_back(8'hEE); rx_q.push_back(8'hEE); rx_q.push_back(8'h77);
    @(negedge clk);
    issue(1, 1'b0, REG_XDATA_L, 8'h00, 4'd1, 1);
    wait_done(1, 400, ok);
    n_tests++;
    if (!ok || done_log.size() != 1 || done_log[0] !== 3'b101 || rd_log.size() != 1 || rd_log[0] !== 9'h177) begin
      n_fail++; $display("FAIL to_recover: got done=%0d rd=%0d expected 1 clean done and rd 177",
                         done_log.size(), rd_log.size());
    end
  endtask

  task automatic test_len_clamp();
    bit ok;
    clear_logs();
    rx_q.delete();
    rx_q.push_back(8'hEE); rx_q.push_back(8'hEE); rx_q.push_back(8'h5A);
    @(negedge clk);
    issue(0, 1'b0, REG_XDATA_L, 8'h00, 4'd0, 1);
    wait_done(1, 400, ok);
    n_tests++;
    if (!ok || tx_log.size() != 3 || rd_log.size() != 1 || rd_log[0] !== 9'h05A) begin
      n_fail++; $display("FAIL len0: got starts=%0d rd=%0d expected 3 starts, 1 rd of 05a",
                         tx_log.size(), rd_log.size());
    end
    clear_logs();
    rx_q.delete();
    rx_q.push_back(8'hEE); rx_q.push_back(8'hEE);
    for (int i = 0; i < 12; i++) rx_q.push_back(8'(8'h80 + i));
    @(negedge clk);
    issue(1, 1'b0, REG_XDATA_L, 8'h00, 4'd15, 1);
    wait_done(1, 600, ok);
    n_tests++;
    if (!ok || tx_log.size() != 10 || rd_log.size() != 8) begin
      n_fail++; $display("FAIL len15: got starts=%0d rd=%0d expected 10 and 8", tx_log.size(), rd_log.size());
    end
    n_tests++;
    if (rd_log.size() == 8 && rd_log[7] !== 9'h187) begin
      n_fail++; $display("FAIL len15_last: got %h expected 187", rd_log[7]);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int seen = 0;
    int c = 0;
    clear_logs();
    rx_q.delete();
    @(negedge clk);
    issue(0, 1'b0, REG_XDATA_L, 8'h00, 4'd4, 1);
    while (seen < 2 && c < 200) begin
      @(posedge clk);
      #1;
      c++;
      if (bus.start) seen++;
    end
    n_tests++;
    if (seen != 2 || bus.ncs_o !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_reach: got starts=%0d ncs=%b expected 2/0", seen, bus.ncs_o);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if (bus.ncs_o !== 1'b1 || bus.start !== 1'b0 || bus.clk_enable !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_async: got ncs=%b start=%b clk_en=%b expected 1/0/0",
                         bus.ncs_o, bus.start, bus.clk_enable);
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    pend0 = 0; pend1 = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_logs();
    @(negedge clk);
    issue(0, 1'b1, REG_POWER_CTL, 8'h02, 4'd0, 1);
    issue(1, 1'b1, REG_FILTER_CTL, 8'h13, 4'd0, 1);
    wait_done(2, 800, ok);
    n_tests++;
    if (!ok || gnt_log.size() != 2 || gnt_log[0] != 0 || gnt_log[1] != 1) begin
      n_fail++; $display("FAIL rstmid_first_grant: got %0d grants first=%0d expected req0 then req1",
                         gnt_log.size(), gnt_log.size() ? gnt_log[0] : -1);
    end
  endtask

  initial begin
    bus.req0_valid = 1'b0; bus.req0_write = 1'b0; bus.req0_addr = 8'h00;
    bus.req0_wdata = 8'h00; bus.req0_len = 4'd0;
    bus.req1_valid = 1'b0; bus.req1_write = 1'b0; bus.req1_addr = 8'h00;
    bus.req1_wdata = 8'h00; bus.req1_len = 4'd0;
    bus.active = 1'b0; bus.rx_data = 8'h00;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    test_write();
    test_read();
    test_back_to_back();
    test_timeout();
    test_len_clamp();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
